// File: rtl/ddr_port1_reader.sv
// MCB user-port-1 frame reader: read bursts over a double-buffered frame, drained into a pixel stream.
// Optional macro DDR_READ_PREFETCH_EN allows a second burst in flight for gapless scan-out.
module ddr_port1_reader #(
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned FRAME1_BASE = 1228800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_calib_done,
  input  logic        enable,
  input  logic        frame_select,
  input  logic        p1_cmd_full,
  output logic        p1_cmd_en,
  output logic [2:0]  p1_cmd_instr,
  output logic [5:0]  p1_cmd_bl,
  output logic [29:0] p1_cmd_byte_addr,
  input  logic        p1_rd_empty,
  input  logic [6:0]  p1_rd_count,
  input  logic [31:0] p1_rd_data,
  input  logic        p1_rd_overflow,
  input  logic        p1_rd_error,
  output logic        p1_rd_en,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_start,
  output logic        error
);

  localparam int unsigned WA_W       = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BC_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned STARVE_MAX = 64;
`ifdef DDR_READ_PREFETCH_EN
  localparam int unsigned MAX_OUT    = 2;
`else
  localparam int unsigned MAX_OUT    = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_STREAM} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_calib_meta;
  logic            r_calib;
  logic            r_sel;
  logic [WA_W-1:0] r_word_addr;
  logic [WA_W-1:0] r_stream_pos;
  logic [BC_W-1:0] r_burst_cnt;
  logic [1:0]      r_outstanding;
  logic [6:0]      r_starve_cnt;
  logic [31:0]     r_pix_data;
  logic            r_pix_valid;
  logic            r_frame_start;
  logic            r_error;

  logic            w_cmd_en;
  logic            w_rd_en;
  logic            w_burst_done;
  logic            w_idle_exit;
  logic            w_starve;
  logic [WA_W-1:0] w_addr_inc;
  logic            w_addr_wrap;
  logic [WA_W-1:0] w_pos_inc;
  logic [29:0]     w_cmd_addr;

  assign w_addr_inc  = r_word_addr + WA_W'(BURST_LEN);
  assign w_addr_wrap = (w_addr_inc >= WA_W'(FRAME_WORDS));
  assign w_pos_inc   = r_stream_pos + WA_W'(1);
  assign w_cmd_addr  = (r_sel ? 30'(FRAME1_BASE) : 30'd0) + (30'(r_word_addr) << 2);
  assign w_starve    = (r_state == S_STREAM) && p1_rd_empty;

  // Command strobe and FIFO pop are combinational so they act on the MCB FIFO flags of the same cycle.
  assign p1_cmd_en        = w_cmd_en;
  assign p1_cmd_instr     = w_cmd_en ? 3'b001 : 3'b000;
  assign p1_cmd_bl        = w_cmd_en ? 6'(BURST_LEN - 1) : 6'd0;
  assign p1_cmd_byte_addr = w_cmd_en ? w_cmd_addr : 30'd0;
  assign p1_rd_en         = w_rd_en;
  assign pix_data         = r_pix_data;
  assign pix_valid        = r_pix_valid;
  assign frame_start      = r_frame_start;
  assign error            = r_error;

  // Two-flop calibration synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_calib_meta <= 1'b0;
      r_calib      <= 1'b0;
    end else begin
      r_calib_meta <= mem_calib_done;
      r_calib      <= r_calib_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, command issue and FIFO pop.
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_en     = 1'b0;
    w_rd_en      = 1'b0;
    w_burst_done = 1'b0;
    w_idle_exit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_calib && enable) begin
          w_idle_exit = 1'b1;
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        if (!p1_cmd_full && (r_outstanding < 2'(MAX_OUT))) begin
          w_cmd_en    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (p1_rd_count >= 7'(BURST_LEN)) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_rd_en = !p1_rd_empty && (!r_pix_valid || pix_ready);
`ifdef DDR_READ_PREFETCH_EN
        w_cmd_en = (r_outstanding == 2'd1) && enable && !p1_cmd_full;
`endif
        if (w_rd_en && (r_burst_cnt == BC_W'(BURST_LEN - 1))) begin
          w_burst_done = 1'b1;
`ifdef DDR_READ_PREFETCH_EN
          // Next burst already fully buffered (head word excluded): keep streaming without a bubble.
          if ((r_outstanding + 2'(w_cmd_en)) > 2'd1)
            w_state_nxt = (p1_rd_count > 7'(BURST_LEN)) ? S_STREAM : S_WAIT;
          else
            w_state_nxt = enable ? S_CMD : S_IDLE;
`else
          w_state_nxt = enable ? S_CMD : S_IDLE;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame address walk, buffer selection and burst bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel         <= 1'b0;
      r_word_addr   <= '0;
      r_stream_pos  <= '0;
      r_burst_cnt   <= '0;
      r_outstanding <= 2'd0;
    end else begin
      if (w_idle_exit) begin
        r_sel       <= frame_select;
        r_word_addr <= '0;
      end else if (w_cmd_en) begin
        if (w_addr_wrap) begin
          r_word_addr <= '0;
          r_sel       <= frame_select;
        end else begin
          r_word_addr <= w_addr_inc;
        end
      end else if ((w_state_nxt == S_IDLE) && (r_state != S_IDLE)) begin
        r_word_addr <= '0;
      end

      if (w_idle_exit)  r_stream_pos <= '0;
      else if (w_rd_en) r_stream_pos <= (w_pos_inc >= WA_W'(FRAME_WORDS)) ? '0 : w_pos_inc;

      if (w_burst_done) r_burst_cnt <= '0;
      else if (w_rd_en) r_burst_cnt <= r_burst_cnt + BC_W'(1);

      r_outstanding <= r_outstanding + 2'(w_cmd_en) - 2'(w_burst_done);
    end
  end

  // Output stream register: one-cycle FIFO-to-stream latency, holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_data    <= 32'd0;
      r_pix_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_rd_en) begin
      r_pix_data    <= p1_rd_data;
      r_pix_valid   <= 1'b1;
      r_frame_start <= (r_stream_pos == '0);
    end else if (pix_ready) begin
      r_pix_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  // Sticky error: FIFO faults or a read FIFO starved mid-burst for too long.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= 7'd0;
      r_error      <= 1'b0;
    end else begin
      if (!w_starve)                            r_starve_cnt <= 7'd0;
      else if (r_starve_cnt != 7'(STARVE_MAX))  r_starve_cnt <= r_starve_cnt + 7'd1;

      if (p1_rd_overflow || p1_rd_error || (w_starve && (r_starve_cnt == 7'(STARVE_MAX))))
        r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_port1_reader.sv
// Directed bench for ddr_port1_reader with a small MCB command/read-FIFO model (BURST_LEN=4, FRAME_WORDS=8).
module tb_ddr_port1_reader;

  localparam int unsigned BL  = 4;
  localparam int unsigned FW  = 8;
  localparam int unsigned F1B = 64;
  localparam int          LAT = 3;

  logic        clk;
  logic        reset_n;
  logic        mem_calib_done;
  logic        enable;
  logic        frame_select;
  logic        p1_cmd_full;
  logic        p1_cmd_en;
  logic [2:0]  p1_cmd_instr;
  logic [5:0]  p1_cmd_bl;
  logic [29:0] p1_cmd_byte_addr;
  logic        p1_rd_empty;
  logic [6:0]  p1_rd_count;
  logic [31:0] p1_rd_data;
  logic        p1_rd_overflow;
  logic        p1_rd_error;
  logic        p1_rd_en;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_start;
  logic        error;

  ddr_port1_reader #(.BURST_LEN(BL), .FRAME_WORDS(FW), .FRAME1_BASE(F1B)) dut (
    .clk(clk), .reset_n(reset_n), .mem_calib_done(mem_calib_done), .enable(enable),
    .frame_select(frame_select), .p1_cmd_full(p1_cmd_full), .p1_cmd_en(p1_cmd_en),
    .p1_cmd_instr(p1_cmd_instr), .p1_cmd_bl(p1_cmd_bl), .p1_cmd_byte_addr(p1_cmd_byte_addr),
    .p1_rd_empty(p1_rd_empty), .p1_rd_count(p1_rd_count), .p1_rd_data(p1_rd_data),
    .p1_rd_overflow(p1_rd_overflow), .p1_rd_error(p1_rd_error), .p1_rd_en(p1_rd_en),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .frame_start(frame_start), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  logic        s_rd;
  logic [31:0] fifo[$];
  logic [29:0] pend_addr[$];
  int          pend_due[$];
  logic [29:0] cmd_addr[$];
  logic [5:0]  cmd_bl[$];
  logic [2:0]  cmd_instr[$];
  logic [31:0] pix_log[$];
  logic        fs_log[$];

  // MCB returns a buffer tag (0x100 for buffer 1) plus the word index within the frame.
  function automatic logic [31:0] exp_word(input logic [29:0] a, input int i);
    return ((a >= 30'd64) ? 32'h100 : 32'h0) + 32'((a % 30'd64) >> 2) + 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present FIFO view, sample strobes mid-cycle, then update the MCB model after the edge.
  task automatic cyc();
    @(negedge clk);
    p1_rd_empty = (fifo.size() == 0);
    p1_rd_count = 7'(fifo.size());
    p1_rd_data  = (fifo.size() != 0) ? fifo[0] : 32'd0;
    #1;
    s_rd = p1_rd_en;
    if (p1_cmd_en) begin
      cmd_addr.push_back(p1_cmd_byte_addr);
      cmd_bl.push_back(p1_cmd_bl);
      cmd_instr.push_back(p1_cmd_instr);
      pend_addr.push_back(p1_cmd_byte_addr);
      pend_due.push_back(cyc_n + LAT);
    end
    if (pix_valid && pix_ready) begin
      pix_log.push_back(pix_data);
      fs_log.push_back(frame_start);
    end
    @(posedge clk);
    #1;
    if (s_rd && (fifo.size() != 0)) void'(fifo.pop_front());
    cyc_n++;
    while ((pend_due.size() != 0) && (pend_due[0] <= cyc_n)) begin
      for (int i = 0; i < int'(BL); i++) fifo.push_back(exp_word(pend_addr[0], i));
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
  endtask

  initial begin
    int n;
    int bp;
    int bc;
    int k;
    logic [31:0] hold;
    logic        stable;
    logic        rd0;
    logic [15:0] fsv;
    logic [29:0] exp_a [5];
    exp_a = '{30'd0, 30'd16, 30'd64, 30'd80, 30'd0};

    reset_n = 1'b0; mem_calib_done = 1'b0; enable = 1'b1; frame_select = 1'b0;
    p1_cmd_full = 1'b0; p1_rd_empty = 1'b1; p1_rd_count = 7'd0; p1_rd_data = 32'd0;
    p1_rd_overflow = 1'b0; p1_rd_error = 1'b0; pix_ready = 1'b1; s_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 32'({p1_cmd_en, p1_rd_en, pix_valid, frame_start, error}), 32'd0);
    chk("rst_cmd", 32'({p1_cmd_instr, p1_cmd_bl}), 32'd0);
    chk("rst_pix", pix_data, 32'd0);

    // No command before calibration, then first command no earlier than cycle 3.
    reset_n = 1'b1;
    repeat (6) cyc();
    chk("no_cmd_precal", 32'(cmd_addr.size()), 32'd0);
    mem_calib_done = 1'b1;
    k = 0;
    while ((k < 20) && (cmd_addr.size() == 0)) begin cyc(); k++; end
    chk("first_cmd_seen", 32'(cmd_addr.size()), 32'd1);
    chk("first_cmd_lat_ge3", 32'(k >= 3), 32'd1);
    if (cmd_addr.size() != 0) begin
      chk("first_addr", 32'(cmd_addr[0]), 32'd0);
      chk("first_bl", 32'(cmd_bl[0]), 32'd3);
      chk("first_instr", 32'(cmd_instr[0]), 32'd1);
    end

    // Stream two frames; frame_select changes mid-frame only take effect at the frame wrap.
    frame_select = 1'b1;
    k = 0;
    while ((k < 300) && !((cmd_addr.size() >= 5) && (pix_log.size() >= 16))) begin
      cyc();
      frame_select = (cmd_addr.size() >= 1) && (cmd_addr.size() < 3);
      k++;
    end
    chk("frames_cmds", 32'(cmd_addr.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < cmd_addr.size()) chk($sformatf("cmd_addr%0d", i), 32'(cmd_addr[i]), 32'(exp_a[i]));
    chk("frames_words", 32'(pix_log.size() >= 16), 32'd1);
    fsv = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < pix_log.size()) begin
        chk($sformatf("pix%0d", i), pix_log[i], (i < 8) ? 32'(i) : 32'h100 + 32'(i - 8));
        fsv[i] = fs_log[i];
      end
    end
    chk("frame_start_pattern", 32'(fsv), 32'h0101);
    chk("no_err_frames", 32'(error), 32'd0);

    // Stall the stream mid-burst for 5 clocks.
    k = 0;
    while ((k < 40) && (pix_log.size() < 17)) begin cyc(); k++; end
    chk("stall_valid", 32'(pix_valid), 32'd1);
    hold = pix_data; stable = 1'b1; rd0 = 1'b1;
    pix_ready = 1'b0;
    repeat (5) begin
      cyc();
      if (pix_data !== hold) stable = 1'b0;
      if (s_rd) rd0 = 1'b0;
    end
    chk("stall_data_stable", 32'(stable), 32'd1);
    chk("stall_no_pop", 32'(rd0), 32'd1);
    chk("stall_no_accept", 32'(pix_log.size()), 32'd17);
    pix_ready = 1'b1;
    k = 0;
    while ((k < 40) && (pix_log.size() < 20)) begin cyc(); k++; end
    for (int i = 16; i < 20; i++)
      if (i < pix_log.size()) chk($sformatf("stall_pix%0d", i), pix_log[i], 32'(i - 16));

    // Command FIFO full holds the strobe off, then exactly one strobe.
    n = cmd_addr.size();
    p1_cmd_full = 1'b1;
    repeat (12) cyc();
    chk("full_no_strobe", 32'(cmd_addr.size() - n), 32'd0);
    p1_cmd_full = 1'b0;
    k = 0;
    while ((k < 20) && (cmd_addr.size() == n)) begin cyc(); k++; end
    cyc();
    chk("single_strobe", 32'(cmd_addr.size() - n), 32'd1);

    // Overflow pulse makes error sticky.
    chk("err_before_ovf", 32'(error), 32'd0);
    p1_rd_overflow = 1'b1;
    cyc();
    p1_rd_overflow = 1'b0;
    chk("err_set", 32'(error), 32'd1);
    repeat (5) cyc();
    chk("err_sticky", 32'(error), 32'd1);

    // Drop enable right after a command at word 0: burst completes, then restart at address 0.
    n = cmd_addr.size();
    k = 0;
    while ((k < 80) && !((cmd_addr.size() > n) && (cmd_addr[$] == 30'd0))) begin cyc(); k++; end
    chk("drop_cmd_seen", 32'(k < 80), 32'd1);
    enable = 1'b0;
    bp = pix_log.size();
    bc = cmd_addr.size();
    repeat (30) cyc();
    chk("drop_words", 32'(pix_log.size() - bp), 32'd4);
    chk("drop_no_cmd", 32'(cmd_addr.size() - bc), 32'd0);
    if (pix_log.size() >= bp + 4) begin
      chk("drop_first", pix_log[bp], 32'd0);
      chk("drop_last", pix_log[bp + 3], 32'd3);
    end
    enable = 1'b1;
    k = 0;
    while ((k < 20) && (cmd_addr.size() == bc)) begin cyc(); k++; end
    chk("restart_seen", 32'(cmd_addr.size() - bc), 32'd1);
    chk("restart_addr", 32'(cmd_addr[$]), 32'd0);

    // Asynchronous reset while streaming clears outputs immediately.
    k = 0;
    while ((k < 30) && (pix_valid !== 1'b1)) begin cyc(); k++; end
    chk("pre_rst_valid", 32'(pix_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_ctl", 32'({p1_cmd_en, p1_rd_en, pix_valid, frame_start, error}), 32'd0);
    chk("async_rst_pix", pix_data, 32'd0);
    chk("async_rst_cmd", 32'({p1_cmd_instr, p1_cmd_bl}), 32'd0);
    chk("async_rst_addr", 32'(p1_cmd_byte_addr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
